inst_decode_stage: RTL and testbench

- Registered, buffered successor to the combinational instruction decoder.
- Accepts fetched instructions and their PC over a valid/ready handshake, decodes the KGP-RISC formats and queues the results in a parametrised FIFO.
- Presents decoded fields and control flags to the execute stage over a second valid/ready handshake.
- Supports pipeline flush on taken branch/jump; sits between fetch and register-read/execute.

---
 rtl/inst_decode_stage_pkg.sv | 46 ++++
 rtl/inst_decode_stage_if.sv | 43 ++++
 rtl/inst_decode_stage_field_decode.sv | 57 +++++
 rtl/inst_decode_stage.sv | 125 ++++++++++++
 tb/tb_inst_decode_stage.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_decode_stage_pkg.sv
// KGP-RISC ISA definitions shared by the decode stage: opcode values,
// instruction field positions and the decoded-entry record.
package kgp_isa_pkg;

    // Opcode values (inst[31:29])
    localparam logic [2:0] OP_ALU    = 3'b000;
    localparam logic [2:0] OP_IMM    = 3'b001;
    localparam logic [2:0] OP_MEM    = 3'b010;
    localparam logic [2:0] OP_JUMP   = 3'b011;
    localparam logic [2:0] OP_BR     = 3'b100;
    localparam logic [2:0] OP_BRCOND = 3'b101;

    // Field slice positions within the 32-bit instruction word
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 29;
    localparam int RS_HI  = 28;
    localparam int RS_LO  = 24;
    localparam int RT_HI  = 23;
    localparam int RT_LO  = 19;
    localparam int SH_HI  = 18;
    localparam int SH_LO  = 14;
    localparam int FN_HI  = 13;
    localparam int FN_LO  = 10;

    // Decoded instruction record; the PC is carried alongside by the FIFO
    typedef struct packed {
        logic [2:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [3:0]  func;
        logic [21:0] imm;
        logic [24:0] label;
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic        is_jump;
        logic        illegal;
    } dec_entry_t;

    // Opcodes 110 and 111 are unassigned
    function automatic logic is_illegal_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/inst_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master: fetch/execute environment; slave: the decode stage itself.
interface inst_decode_stage_if #(
    parameter int PC_W   = 32,
    parameter int REG_AW = 5
);
    // Fetch side
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic [PC_W-1:0]   pc;
    logic              flush;

    // Execute side
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [2:0]        opcode;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [4:0]        shamt;
    logic [3:0]        func;
    logic [21:0]       imm;
    logic [24:0]       label;
    logic              mem_write;
    logic              mem_read;
    logic              reg_write;
    logic              is_jump;
    logic              illegal;

    modport master (
        output in_valid, inst, pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rs_addr, rt_addr, shamt,
               func, imm, label, mem_write, mem_read, reg_write, is_jump, illegal
    );

    modport slave (
        input  in_valid, inst, pc, flush, out_ready,
        output in_ready, out_valid, out_pc, opcode, rs_addr, rt_addr, shamt,
               func, imm, label, mem_write, mem_read, reg_write, is_jump, illegal
    );

endinterface

// File: rtl/inst_decode_stage_field_decode.sv
// Combinational KGP-RISC field decoder: instruction word -> decoded record.
// Fields not used by an opcode are zero.
module inst_field_decode
    import kgp_isa_pkg::*;
(
    input  logic [31:0] inst_i,
    output dec_entry_t  dec_o
);

    // Slice fields per opcode, then derive the control flags
    always_comb begin
        // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
        dec_o        = '0;
        dec_o.opcode = inst_i[OPC_HI:OPC_LO];
        case (inst_i[OPC_HI:OPC_LO])
            OP_ALU: begin
                dec_o.rs    = inst_i[RS_HI:RS_LO];
                dec_o.rt    = inst_i[RT_HI:RT_LO];
                dec_o.shamt = inst_i[SH_HI:SH_LO];
                dec_o.func  = inst_i[FN_HI:FN_LO];
            end
            OP_IMM: begin
                dec_o.rs   = inst_i[RS_HI:RS_LO];
                dec_o.func = {2'b00, inst_i[1:0]};
                dec_o.imm  = inst_i[23:2];
            end
            OP_MEM: begin
                dec_o.rs   = inst_i[RS_HI:RS_LO];
                dec_o.rt   = inst_i[RT_HI:RT_LO];
                dec_o.func = {3'b000, inst_i[0]};
                dec_o.imm  = {4'b0000, inst_i[18:1]};
            end
            OP_JUMP: begin
                dec_o.func  = inst_i[3:0];
                dec_o.label = inst_i[28:4];
            end
            OP_BR: begin
                dec_o.rs = inst_i[RS_HI:RS_LO];
            end
            OP_BRCOND: begin
                dec_o.rs    = inst_i[RS_HI:RS_LO];
                dec_o.label = {5'b00000, inst_i[23:4]};
                dec_o.func  = inst_i[3:0];
            end
            default: ;
        endcase

        dec_o.illegal   = is_illegal_op(dec_o.opcode);
        dec_o.mem_write = (dec_o.opcode == OP_MEM) && (dec_o.func == 4'd1);
        dec_o.mem_read  = (dec_o.opcode == OP_MEM) && (dec_o.func == 4'd0);
        dec_o.reg_write = (dec_o.opcode == OP_ALU) || (dec_o.opcode == OP_IMM) ||
                          dec_o.mem_read;
        dec_o.is_jump   = (dec_o.opcode == OP_JUMP) || (dec_o.opcode == OP_BR) ||
                          (dec_o.opcode == OP_BRCOND);
    end

endmodule

// File: rtl/inst_decode_stage.sv
// Registered instruction decode stage: decodes at FIFO write, presents the
// head entry to execute from registers. Flush empties the queue.
// Optional macro ILLEGAL_TRAP_EN: sticky illegal_trap output that stalls the
// stage after an illegal entry is consumed, until flush or rst.
module inst_decode_stage
    import kgp_isa_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2,
    parameter int REG_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    inst_decode_stage_if.slave bus
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             illegal_trap
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        dec_entry_t      dec;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head;
    dec_entry_t      wr_dec;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    logic            trap_blk;

    inst_field_decode u_field_decode (
        .inst_i (bus.inst),
        .dec_o  (wr_dec)
    );

`ifdef ILLEGAL_TRAP_EN
    logic trap_q, trap_d;

    // Trap sets when an illegal head is consumed; flush clears it
    always_comb begin
        trap_d = bus.flush ? 1'b0 : (trap_q | (pop & head.dec.illegal));
    end

    // Trap register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) trap_q <= 1'b0;
        else     trap_q <= trap_d;
    end

    assign trap_blk     = trap_q;
    assign illegal_trap = trap_q;
`else
    assign trap_blk = 1'b0;
`endif

    // A pop from a full queue frees a slot in the same cycle
    assign bus.in_ready  = !trap_blk && ((count_q < CW'(DEPTH)) || bus.out_ready);
    assign bus.out_valid = !trap_blk && (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop           = bus.out_valid && bus.out_ready;

    // Pointer and occupancy next state; flush overrides push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written with the decoded instruction on accept
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: storage is reset so the head outputs read all-zero out of reset.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{pc: bus.pc, dec: wr_dec};
        end
    end

    // Head outputs come straight from the stored entry
    assign head          = mem_q[rd_ptr_q];
    assign bus.out_pc    = head.pc;
    assign bus.opcode    = head.dec.opcode;
    assign bus.rs_addr   = REG_AW'(head.dec.rs);
    assign bus.rt_addr   = REG_AW'(head.dec.rt);
    assign bus.shamt     = head.dec.shamt;
    assign bus.func      = head.dec.func;
    assign bus.imm       = head.dec.imm;
    assign bus.label     = head.dec.label;
    assign bus.mem_write = head.dec.mem_write;
    assign bus.mem_read  = head.dec.mem_read;
    assign bus.reg_write = head.dec.reg_write;
    assign bus.is_jump   = head.dec.is_jump;
    assign bus.illegal   = head.dec.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_inst_decode_stage;

    localparam int PC_W   = 32;
    localparam int DEPTH  = 2;
    localparam int REG_AW = 5;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [3:0]  func;
        logic [21:0] imm;
        logic [24:0] label;
        logic        mw;
        logic        mr;
        logic        rw;
        logic        jmp;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_decode_stage_if #(.PC_W(PC_W), .REG_AW(REG_AW)) bus ();
`ifdef ILLEGAL_TRAP_EN
    logic illegal_trap;
`endif

    inst_decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_trap (illegal_trap)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   trap_m = 1'b0;

    // Reference decode written from the ISA field rules with shifts and masks
    function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] p);
        exp_t e;
        int unsigned op;
        e    = '0;
        e.pc = p;
        op   = w >> 29;
        e.op = 3'(op);
        case (op)
            0: begin
                e.rs = 5'((w >> 24) & 32'h1F); e.rt = 5'((w >> 19) & 32'h1F);
                e.shamt = 5'((w >> 14) & 32'h1F); e.func = 4'((w >> 10) & 32'hF);
            end
            1: begin
                e.rs = 5'((w >> 24) & 32'h1F); e.func = 4'(w & 32'h3);
                e.imm = 22'((w >> 2) & 32'h3FFFFF);
            end
            2: begin
                e.rs = 5'((w >> 24) & 32'h1F); e.rt = 5'((w >> 19) & 32'h1F);
                e.func = 4'(w & 32'h1); e.imm = 22'((w >> 1) & 32'h3FFFF);
            end
            3: begin
                e.func = 4'(w & 32'hF); e.label = 25'((w >> 4) & 32'h1FFFFFF);
            end
            4: e.rs = 5'((w >> 24) & 32'h1F);
            5: begin
                e.rs = 5'((w >> 24) & 32'h1F); e.label = 25'((w >> 4) & 32'hFFFFF);
                e.func = 4'(w & 32'hF);
            end
            default: e.ill = 1'b1;
        endcase
        e.mw  = (op == 2) && ((w & 32'h1) == 32'h1);
        e.mr  = (op == 2) && ((w & 32'h1) == 32'h0);
        e.rw  = (op <= 1) || e.mr;
        e.jmp = (op >= 3) && (op <= 5);
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o.pc = bus.out_pc; o.op = bus.opcode; o.rs = bus.rs_addr; o.rt = bus.rt_addr;
        o.shamt = bus.shamt; o.func = bus.func; o.imm = bus.imm; o.label = bus.label;
        o.mw = bus.mem_write; o.mr = bus.mem_read; o.rw = bus.reg_write;
        o.jmp = bus.is_jump; o.ill = bus.illegal;
        return o;
    endfunction

    function automatic bit exp_ready();
        return !trap_m && ((q.size() < DEPTH) || (bus.out_ready == 1'b1));
    endfunction

    function automatic bit exp_valid();
        return !trap_m && (q.size() != 0);
    endfunction

    function automatic logic [31:0] rand_inst(input bit allow_illegal);
        logic [31:0] w;
        logic [2:0]  op;
        w  = $urandom;
        op = 3'($urandom_range(0, 7));
        if (op[2] && op[1] && (!allow_illegal || $urandom_range(0, 3) != 0))
            op = 3'($urandom_range(0, 5));
        w[31:29] = op;
        return w;
    endfunction

    task automatic drive(input bit v, input logic [31:0] w, input logic [31:0] p,
                         input bit rdy, input bit fl);
        bus.in_valid  = v;
        bus.inst      = w;
        bus.pc        = p;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
    endtask

    // Advance the model by the handshake about to happen, then clock it in
    task automatic tick();
        bit acc, pop;
        acc = (bus.in_valid == 1'b1) && exp_ready();
        pop = exp_valid() && (bus.out_ready == 1'b1);
        if (bus.flush == 1'b1) begin
            q.delete();
            trap_m = 1'b0;
        end else begin
            if (pop) begin
                if (TRAP_EN && q[0].ill) trap_m = 1'b1;
                q.delete(0);
            end
            if (acc) q.push_back(model_decode(bus.inst, bus.pc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 0, 0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        q.delete();
        trap_m = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (obs() !== exp_t'('0)) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", obs());
        end
        drive(1, 32'h0A2C4C00, 32'h40, 1, 0);
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        e = '0; e.pc = 32'h40; e.rs = 5'd10; e.rt = 5'd5; e.shamt = 5'd17;
        e.func = 4'd3; e.rw = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b1 || obs() !== e) begin
            errors++;
            $display("FAIL basic_alu: got valid=%b %h expected valid=1 %h", bus.out_valid, obs(), e);
        end
        tick();
    endtask

    task automatic test_store_load();
        logic [31:0] st, ld;
        st = 32'h43102469;
        ld = 32'h43102468;
        drive(1, st, 32'h100, 1, 0);
        tick();
        drive(1, ld, 32'h104, 1, 0);
        checks++;
        if (bus.out_valid !== 1'b1 || obs() !== q[0] || bus.mem_write !== 1'b1 ||
            bus.mem_read !== 1'b0 || bus.imm[21:17] !== 5'd0) begin
            errors++; $display("FAIL store: got %h expected %h", obs(), q[0]);
        end
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        checks++;
        if (bus.out_valid !== 1'b1 || obs() !== q[0] || bus.mem_write !== 1'b0 ||
            bus.mem_read !== 1'b1 || bus.reg_write !== 1'b1 || bus.imm !== 22'h1234) begin
            errors++; $display("FAIL load: got %h expected %h", obs(), q[0]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] w[3];
        exp_t        ea, eb, ec;
        for (int i = 0; i < 3; i++) w[i] = rand_inst(0);
        ea = model_decode(w[0], 32'h200);
        eb = model_decode(w[1], 32'h204);
        ec = model_decode(w[2], 32'h208);
        for (int i = 0; i < 2; i++) begin
            drive(1, w[i], 32'h200 + 32'(4 * i), 0, 0);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL bp_fill_ready%0d: got %b expected 1", i, bus.in_ready);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, w[2], 32'h208, 0, 0);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || obs() !== ea) begin
                errors++;
                $display("FAIL bp_full_hold%0d: got ready=%b %h expected ready=0 %h",
                         i, bus.in_ready, obs(), ea);
            end
            tick();
        end
        drive(1, w[2], 32'h208, 1, 0);
        checks++;
        if (bus.in_ready !== 1'b1 || obs() !== ea) begin
            errors++; $display("FAIL bp_pop_push: got ready=%b %h expected ready=1 %h",
                               bus.in_ready, obs(), ea);
        end
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        checks++;
        if (bus.out_valid !== 1'b1 || obs() !== eb) begin
            errors++; $display("FAIL bp_order_b: got %h expected %h", obs(), eb);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || obs() !== ec) begin
            errors++; $display("FAIL bp_order_c: got %h expected %h", obs(), ec);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drained: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            drive(1, rand_inst(0), 32'h300 + 32'(4 * i), 0, 0);
            tick();
        end
        drive(1, 32'h0A2C4C00, 32'h3F0, 1, 1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ready: got %b expected 1", bus.in_ready);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 32'h0, 1, 0);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL flush_empty%0d: got valid=%b ready=%b expected valid=0 ready=1",
                                   i, bus.out_valid, bus.in_ready);
            end
            tick();
        end
        drive(1, rand_inst(0), 32'h310, 0, 0);
        tick();
        drive(1, rand_inst(0), 32'h314, 0, 1);
        tick();
        drive(0, 32'h0, 32'h0, 0, 0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_one: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        drive(1, 32'hE0000000, 32'h400, 0, 0);
        tick();
        drive(0, 32'h0, 32'h0, 0, 0);
        e = '0; e.pc = 32'h400; e.op = 3'b111; e.ill = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b1 || obs() !== e) begin
            errors++; $display("FAIL illegal_fields: got %h expected %h", obs(), e);
        end
        drive(0, 32'h0, 32'h0, 1, 0);
        tick();
        drive(1, 32'h0A2C4C00, 32'h404, 1, 0);
`ifdef ILLEGAL_TRAP_EN
        checks++;
        if (illegal_trap !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL trap_set: got trap=%b ready=%b valid=%b expected 1 0 0",
                               illegal_trap, bus.in_ready, bus.out_valid);
        end
        tick();
        checks++;
        if (illegal_trap !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL trap_hold: got trap=%b valid=%b expected 1 0",
                               illegal_trap, bus.out_valid);
        end
        drive(0, 32'h0, 32'h0, 0, 1);
        tick();
        drive(0, 32'h0, 32'h0, 0, 0);
        checks++;
        if (illegal_trap !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL trap_clear: got trap=%b ready=%b valid=%b expected 0 1 0",
                               illegal_trap, bus.in_ready, bus.out_valid);
        end
`else
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL illegal_flow: got ready=%b valid=%b expected 1 0",
                               bus.in_ready, bus.out_valid);
        end
        tick();
        drive(0, 32'h0, 32'h0, 1, 0);
        tick();
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), rand_inst(1), $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
            checks++;
            if (bus.in_ready !== exp_ready() || bus.out_valid !== exp_valid()) begin
                errors++; $display("FAIL rand_hs cycle %0d: got ready=%b valid=%b expected ready=%b valid=%b",
                                   n, bus.in_ready, bus.out_valid, exp_ready(), exp_valid());
            end
            if (exp_valid()) begin
                checks++;
                if (obs() !== q[0]) begin
                    errors++; $display("FAIL rand_head cycle %0d: got %h expected %h", n, obs(), q[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(0, 32'h0, 32'h0, 0, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, rand_inst(0), 32'h500 + 32'(4 * i), 0, 0);
            tick();
        end
        drive(0, 32'h0, 32'h0, 0, 0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL areset_full: got valid=%b ready=%b expected 1 0",
                               bus.out_valid, bus.in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_immediate: got valid=%b ready=%b expected 0 1",
                               bus.out_valid, bus.in_ready);
        end
        q.delete();
        trap_m = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || obs() !== exp_t'('0)) begin
            errors++; $display("FAIL areset_after: got valid=%b %h expected 0 0", bus.out_valid, obs());
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_flush();
        test_illegal();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
